// File: rtl/multi_digit_tube.sv
// N-digit multiplexed seven-segment driver with a serial double-dabble
// binary-to-BCD converter, leading-zero blanking and overflow dashes.
module multi_digit_tube #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 14,
  parameter int SCAN_DIV    = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] Number_Data,
  input  logic              Load,
  input  logic              Blank_Lead,
  input  logic [DIGITS-1:0] Dp_Mask,
  output logic              Busy,
  output logic              Overflow,
  output logic [7:0]        Row_Scan_Sig,
  output logic [DIGITS-1:0] Column_Scan_Sig
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  localparam int BW = 4 * DIGITS;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LOW}};
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  logic              busy_q, ovf_q, lead_q;
  logic [NW-1:0]     step_q;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [BW-1:0]     disp_q;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              dash_q;
  logic [CW-1:0]     scan_q;
  logic [IW-1:0]     idx_q;
  logic [7:0]        row_q, row_d;
  logic [DIGITS-1:0] col_q, col_d;
  logic              load_ok, last_step, seen;
  logic [3:0]        nib;
  logic [7:0]        code;
  logic [DIGITS-1:0] hot;

  assign load_ok   = Load & ~busy_q;
  assign last_step = (step_q == NW'(DATA_W - 1));

  // One shift-add-3 step; blanking is derived from the post-step value
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < DIGITS; i++)
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    acc_d = {acc_d[BW-2:0], bin_q[DATA_W-1]};
    bin_d = bin_q << 1;
    blank_d = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (acc_d[4*i +: 4] != 4'd0) seen = 1'b1;
      blank_d[i] = lead_q & ~seen;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lead_q  <= 1'b0;
      step_q  <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      disp_q  <= '0;
      blank_q <= BLANK_RST;
      dash_q  <= 1'b0;
    end else if (load_ok) begin
      bin_q  <= Number_Data;
      acc_q  <= '0;
      lead_q <= Blank_Lead;
      ovf_q  <= (64'(Number_Data) >= LIMIT);
      busy_q <= 1'b1;
      step_q <= '0;
    end else if (busy_q) begin
      if (ovf_q) begin
        busy_q  <= 1'b0;
        dash_q  <= 1'b1;
        blank_q <= '0;
      end else begin
        acc_q  <= acc_d;
        bin_q  <= bin_d;
        step_q <= step_q + 1'b1;
        if (last_step) begin
          busy_q  <= 1'b0;
          disp_q  <= acc_d;
          blank_q <= blank_d;
          dash_q  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    nib = disp_q[4*idx_q +: 4];
    code = seg_code(nib);
    if (blank_q[idx_q]) code = 8'hFF;
    if (dash_q) code = 8'hBF;
    if (Dp_Mask[idx_q]) code[7] = 1'b0;
    row_d = SEG_ACT_LOW ? code : ~code;
    hot = '0;
    hot[idx_q] = 1'b1;
    col_d = DIG_ACT_LOW ? ~hot : hot;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_q <= '0;
      idx_q  <= '0;
      row_q  <= SEG_OFF;
      col_q  <= DIG_OFF;
    end else begin
      if (scan_q == CW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign Busy            = busy_q;
  assign Overflow        = ovf_q;
  assign Row_Scan_Sig    = row_q;
  assign Column_Scan_Sig = col_q;

endmodule
